// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one single-precision multiplier among NREQ
// requesters: registered operands in, registered product and owner ID out.
`timescale 1ns/1ps

module fp_multiplier_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic        w_sign;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [47:0] w_prod;
  logic [22:0] w_frac;
  logic        w_guard, w_sticky, w_round;
  logic [24:0] w_mant;
  logic [22:0] w_frac_out;
  logic [9:0]  w_esum;
  logic [9:0]  w_ebias;

  always_comb begin
    w_sign   = a[31] ^ b[31];
    w_ea     = a[30:23];
    w_eb     = b[30:23];
    w_ma     = a[22:0];
    w_mb     = b[22:0];
    w_a_nan  = (w_ea == 8'hFF) && (w_ma != 23'd0);
    w_b_nan  = (w_eb == 8'hFF) && (w_mb != 23'd0);
    w_a_inf  = (w_ea == 8'hFF) && (w_ma == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (w_mb == 23'd0);
    // Subnormal inputs are flushed to zero.
    w_a_zero = (w_ea == 8'h00);
    w_b_zero = (w_eb == 8'h00);
    w_prod   = {24'd0, 1'b1, w_ma} * {24'd0, 1'b1, w_mb};
    if (w_prod[47]) begin
      w_frac   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
    end else begin
      w_frac   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_round    = w_guard & (w_sticky | w_frac[0]);
    w_mant     = {2'b01, w_frac} + {24'd0, w_round};
    w_frac_out = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
    // Biased sum kept unsigned: exponent = w_esum - 127, valid range 128..381.
    w_esum     = {2'b00, w_ea} + {2'b00, w_eb} + {9'd0, w_prod[47]} + {9'd0, w_mant[24]};
    w_ebias    = w_esum - 10'd127;

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      result = 32'h7FC00000;
    else if (w_a_inf || w_b_inf)
      result = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      result = {w_sign, 31'd0};
    else if (w_esum >= 10'd382)
      result = {w_sign, 8'hFF, 23'd0};
    else if (w_esum <= 10'd127)
      result = {w_sign, 31'd0};
    else
      result = {w_sign, w_ebias[7:0], w_frac_out};
  end
endmodule

module fp_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_op_id;
  logic [31:0]    r_op_a, r_op_b;
  logic [31:0]    r_rsp_result;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_valid;
  logic           r_busy;

  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_ptr_next;
  logic           w_accept;
  logic [31:0]    w_mul;

  // Rotating priority search starting at r_ptr.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_idx   = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_idx   = IDW'(j);
      end
    end
  end

  assign w_accept   = (r_state == IDLE) && w_found && !rst;
  assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign req_ready[gi] = w_accept && (w_idx == IDW'(gi));
  end

  fp_multiplier_32 u_mul (
    .a      (r_op_a),
    .b      (r_op_b),
    .result (w_mul)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_op_id      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op_a  <= req_a[w_idx*32 +: 32];
            r_op_b  <= req_b[w_idx*32 +: 32];
            r_op_id <= w_idx;
            r_ptr   <= w_ptr_next;
            r_state <= CALC;
            r_busy  <= 1'b1;
          end
        end
        CALC: begin
          r_rsp_result <= w_mul;
          r_rsp_id     <= r_op_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;
endmodule
